// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit engine: FSM state encoding and bit-timing helper.
package uart_tx_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_engine_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and raises tick on the last count.
module uart_tx_engine_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic PARITY_INIT = (PARITY_ODD != 0);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       baud_tick;
  logic       baud_clear;

  // The counter sits at zero while idle and restarts on every state entry.
  assign baud_clear = (state_q == ST_IDLE) || (state_d != state_q);

  uart_tx_engine_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  // Handshake: a byte transfers on any rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and does not depend on tx_valid.
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_STOP) && baud_tick && (bit_idx_q == LAST_STOP);
  assign tx       = tx_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          parity_d  = PARITY_INIT;
          bit_idx_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          parity_d = parity_q ^ shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line level is registered from the next state so tx changes with the state flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine at 16 clocks per bit: 8N1, 8E2 and 8O1 instances.
module tb_uart_tx_engine;

  localparam int N        = 16;
  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [2:0] ready_v, tx_v, busy_v, done_v;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_8n1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0])
  );

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2)) u_8e2 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1])
  );

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2])
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  // Samples each line bit at its midpoint; bit i of bits is the i-th bit on the line.
  task automatic capture_frame(input int s, input int nbits, output logic [11:0] bits,
                               output int start_cyc, output int done_cyc, output int ready_hi);
    int k;
    int guard;
    bits = '1;
    start_cyc = -1;
    done_cyc = -1;
    ready_hi = 0;
    guard = 0;
    while (tx_v[s] !== 1'b0 && guard < 400) begin
      step();
      guard++;
    end
    if (tx_v[s] !== 1'b0) return;
    start_cyc = cyc;
    k = 0;
    for (int i = 0; i < nbits; i++) begin
      while (k < i * N + N / 2) begin
        step();
        k++;
        if (ready_v[s] === 1'b1) ready_hi++;
        if (done_v[s] === 1'b1 && done_cyc < 0) done_cyc = cyc;
      end
      bits[i] = tx_v[s];
    end
    guard = 0;
    while (done_cyc < 0 && guard < 3 * N) begin
      step();
      guard++;
      if (ready_v[s] === 1'b1 && done_v[s] !== 1'b1) ready_hi++;
      if (done_v[s] === 1'b1) done_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (tx_v !== 3'b111) begin
      n_fail++; $display("FAIL reset_tx: got %b expected %b", tx_v, 3'b111);
    end
    n_cmp++;
    if (ready_v !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b expected %b", ready_v, 3'b111);
    end
    n_cmp++;
    if (busy_v !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy: got %b expected %b", busy_v, 3'b000);
    end
    n_cmp++;
    if (done_v !== 3'b000) begin
      n_fail++; $display("FAIL reset_done: got %b expected %b", done_v, 3'b000);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({tx_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected %b",
                         {tx_v[0], ready_v[0], busy_v[0]}, 3'b110);
    end
  endtask

  task automatic test_single();
    logic [11:0] bits;
    int st, dn, rh;
    apply_reset();
    tx_data = 8'h11;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n_cmp++;
    if ({tx_v[0], busy_v[0], ready_v[0]} !== 3'b010) begin
      n_fail++; $display("FAIL accept_latency: got %b expected %b",
                         {tx_v[0], busy_v[0], ready_v[0]}, 3'b010);
    end
    capture_frame(0, 10, bits, st, dn, rh);
    n_cmp++;
    if (bits[9:0] !== 10'b1_0001_0001_0) begin
      n_fail++; $display("FAIL frame_11: got %b expected %b", bits[9:0], 10'b1_0001_0001_0);
    end
    n_cmp++;
    if (st < 0 || dn < 0 || (dn - st + 1) !== 10 * N) begin
      n_fail++; $display("FAIL frame_len_11: got %0d expected %0d", dn - st + 1, 10 * N);
    end
    n_cmp++;
    if (rh !== 0) begin
      n_fail++; $display("FAIL ready_in_frame_11: got %0d expected %0d", rh, 0);
    end
    step();
    n_cmp++;
    if ({tx_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
      n_fail++; $display("FAIL idle_after_11: got %b expected %b",
                         {tx_v[0], ready_v[0], busy_v[0], done_v[0]}, 4'b1100);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits;
    int st1, dn1, st2, dn2, rh;
    apply_reset();
    tx_data = 8'h93;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h55;
    capture_frame(0, 10, bits, st1, dn1, rh);
    n_cmp++;
    if (bits[9:0] !== 10'b1_1001_0011_0) begin
      n_fail++; $display("FAIL frame_93: got %b expected %b", bits[9:0], 10'b1_1001_0011_0);
    end
    n_cmp++;
    if (rh !== 0) begin
      n_fail++; $display("FAIL ready_in_frame_93: got %0d expected %0d", rh, 0);
    end
    step();
    n_cmp++;
    if ({tx_v[0], ready_v[0]} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_idle_cycle: got %b expected %b", {tx_v[0], ready_v[0]}, 2'b11);
    end
    step();
    tx_valid = 1'b0;
    n_cmp++;
    if ({tx_v[0], ready_v[0]} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_second_start: got %b expected %b", {tx_v[0], ready_v[0]}, 2'b00);
    end
    capture_frame(0, 10, bits, st2, dn2, rh);
    n_cmp++;
    if (bits[9:0] !== 10'b1_0101_0101_0) begin
      n_fail++; $display("FAIL frame_55: got %b expected %b", bits[9:0], 10'b1_0101_0101_0);
    end
    n_cmp++;
    if (st2 - dn1 !== 2) begin
      n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", st2 - dn1, 2);
    end
    n_cmp++;
    if (dn2 < 0 || (dn2 - st2 + 1) !== 10 * N) begin
      n_fail++; $display("FAIL frame_len_55: got %0d expected %0d", dn2 - st2 + 1, 10 * N);
    end
  endtask

  task automatic test_parity();
    logic [11:0] bits;
    int st, dn, rh;
    apply_reset();
    tx_data = 8'h07;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    capture_frame(1, 12, bits, st, dn, rh);
    n_cmp++;
    if (bits !== 12'b11_1_0000_0111_0) begin
      n_fail++; $display("FAIL frame_07_even: got %b expected %b", bits, 12'b11_1_0000_0111_0);
    end
    n_cmp++;
    if (st < 0 || dn < 0 || (dn - st + 1) !== 12 * N) begin
      n_fail++; $display("FAIL frame_len_8e2: got %0d expected %0d", dn - st + 1, 12 * N);
    end
    n_cmp++;
    if (dn - (st + 10 * N) + 1 !== 2 * N) begin
      n_fail++; $display("FAIL stop_len_8e2: got %0d expected %0d", dn - (st + 10 * N) + 1, 2 * N);
    end
    apply_reset();
    tx_data = 8'h07;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    capture_frame(2, 11, bits, st, dn, rh);
    n_cmp++;
    if (bits[10:0] !== 11'b1_0_0000_0111_0) begin
      n_fail++; $display("FAIL frame_07_odd: got %b expected %b", bits[10:0], 11'b1_0_0000_0111_0);
    end
    n_cmp++;
    if (st < 0 || dn < 0 || (dn - st + 1) !== 11 * N) begin
      n_fail++; $display("FAIL frame_len_8o1: got %0d expected %0d", dn - st + 1, 11 * N);
    end
  endtask

  task automatic test_busy_ignore();
    logic [11:0] bits;
    int st, dn, rh;
    apply_reset();
    tx_data = 8'h22;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    fork
      capture_frame(0, 10, bits, st, dn, rh);
      begin
        repeat (3 * N) step();
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
      end
    join
    n_cmp++;
    if (bits[9:0] !== 10'b1_0010_0010_0) begin
      n_fail++; $display("FAIL frame_22: got %b expected %b", bits[9:0], 10'b1_0010_0010_0);
    end
    n_cmp++;
    if (rh !== 0) begin
      n_fail++; $display("FAIL ready_in_frame_22: got %0d expected %0d", rh, 0);
    end
    step();
    n_cmp++;
    if ({tx_v[0], ready_v[0]} !== 2'b11) begin
      n_fail++; $display("FAIL idle_after_22: got %b expected %b", {tx_v[0], ready_v[0]}, 2'b11);
    end
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    capture_frame(0, 10, bits, st, dn, rh);
    n_cmp++;
    if (bits[9:0] !== 10'b1_1111_1111_0) begin
      n_fail++; $display("FAIL frame_ff: got %b expected %b", bits[9:0], 10'b1_1111_1111_0);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] bits;
    int st, dn, rh, bad;
    apply_reset();
    tx_data = 8'h88;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (4 * N + N / 2) step();
    n_cmp++;
    if ({tx_v[0], busy_v[0]} !== 2'b11) begin
      n_fail++; $display("FAIL data_bit3_88: got %b expected %b", {tx_v[0], busy_v[0]}, 2'b11);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if ({tx_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
      n_fail++; $display("FAIL mid_reset_next: got %b expected %b",
                         {tx_v[0], ready_v[0], busy_v[0], done_v[0]}, 4'b1100);
    end
    repeat (2) step();
    n_cmp++;
    if ({tx_v, ready_v, busy_v, done_v} !== 12'b111_111_000_000) begin
      n_fail++; $display("FAIL mid_reset_held: got %b expected %b",
                         {tx_v, ready_v, busy_v, done_v}, 12'b111_111_000_000);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 2 * N; i++) begin
      step();
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL post_reset_quiet: got %0d expected %0d", bad, 0);
    end
    tx_data = 8'h44;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    capture_frame(0, 10, bits, st, dn, rh);
    n_cmp++;
    if (bits[9:0] !== 10'b1_0100_0100_0) begin
      n_fail++; $display("FAIL frame_44: got %b expected %b", bits[9:0], 10'b1_0100_0100_0);
    end
    n_cmp++;
    if (st < 0 || dn < 0 || (dn - st + 1) !== 10 * N) begin
      n_fail++; $display("FAIL frame_len_44: got %0d expected %0d", dn - st + 1, 10 * N);
    end
  endtask

  task automatic test_valid_at_release();
    logic [11:0] bits;
    int st, dn, rh;
    reset = 1'b1;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    tx_valid = 1'b0;
    n_cmp++;
    if ({tx_v[0], busy_v[0]} !== 2'b01) begin
      n_fail++; $display("FAIL release_accept: got %b expected %b", {tx_v[0], busy_v[0]}, 2'b01);
    end
    capture_frame(0, 10, bits, st, dn, rh);
    n_cmp++;
    if (bits[9:0] !== 10'b1_0101_1010_0) begin
      n_fail++; $display("FAIL frame_5a: got %b expected %b", bits[9:0], 10'b1_0101_1010_0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_busy_ignore();
    test_reset_mid();
    test_valid_at_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
